fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter in the wr_clk domain.
- Shares the single write port of the 16x8 asynchronous FIFO among NUM_REQ requesters using per-requester valid/ready handshakes.
- Grants one requester a burst of up to MAX_BURST beats, then rotates; honours the FIFO full flag so no beat is lost or duplicated.
- Sits between the requester logic and the FIFO write interface (wr_en, wr_data, full).

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- DATA_W, 8, data width per requester and of the FIFO write data.
- MAX_BURST, 4, maximum beats per grant; 1..16.

Ports:
- wr_clk  input  1  write-domain clock.
- wr_rst  input  1  reset; asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high.
- fifo_full  input  1  FIFO full flag, registered in the wr_clk domain.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_wr_data  output  DATA_W  FIFO write data.
- grant_valid  output  1  high while a burst grant is held (state BURST).
- grant_id  output  clog2(NUM_REQ)  currently or last granted requester.

Behaviour:
- Reset (wr_rst low, async):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - All outputs 0: grant_valid, req_ready, fifo_wr_en, fifo_wr_data.
  - Reset mid-burst aborts the burst with no write that cycle. Requesters keep valid asserted and re-arbitrate after release.
- State IDLE:
  - If req_valid is nonzero, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Register the winner into grant_id, clear beat_cnt, go to BURST.
  - No ready or write is issued in IDLE; arbitration costs exactly 1 cycle.
- State BURST, with g = grant_id:
  - req_ready[g] = !fifo_full; all other ready bits 0.
  - fifo_wr_en = req_valid[g] & !fifo_full, combinational.
  - fifo_wr_data = req_data[g]; it is 0 when grant_valid is 0.
  - beat_cnt increments on each transfer, width clog2(MAX_BURST)+1.
- Exit BURST to IDLE with rr_ptr = (g+1) mod NUM_REQ when either:
  - a transfer occurs with beat_cnt == MAX_BURST-1, or
  - req_valid[g] is 0 in any cycle (early release, with or without full).
- fifo_full high with req_valid[g] high: hold BURST, no transfer, beat_cnt frozen. There is no timeout.
- MAX_BURST=1: every beat is followed by one IDLE cycle.
- Throughput: MAX_BURST beats per MAX_BURST+1 cycles when not full.
- Simultaneous requests: only the round-robin winner is served; losers keep valid asserted and are served in rotation. A requester waits at most (NUM_REQ-1) bursts.
- Requesters must hold data stable while valid is high and ready is low.
- req_data of non-granted requesters is ignored.
- fifo_wr_en is never asserted while fifo_full is high.

Test Plan:
- Reset release, req_valid=0 for 10 cycles -> grant_valid=0, fifo_wr_en=0, req_ready=0 throughout.
- req_valid=4'b0001, data 0x10,0x11,... continuous -> IDLE 1 cycle, then 4 writes 0x10..0x13, 1 IDLE cycle, grant_id=0 again, next writes 0x14..0x17.
- req_valid=4'b1111 held -> grant order 0,1,2,3,0; each burst 4 beats; 16 writes in 20 cycles; data tagged per requester in that order.
- Requester 2 granted, fifo_full forced high after beat 2 for 5 cycles -> fifo_wr_en=0 and req_ready[2]=0 during full; beats 3-4 written after full drops; no loss or duplicate.
- Requester 1 drops valid after 2 beats while requester 3 is valid -> exit after 2 writes; next grant_id=3.
- wr_rst pulsed low mid-burst (beat 2 of requester 2) -> outputs 0 immediately; after release, first grant goes to the lowest valid requester starting from 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin burst arbiter sharing one FIFO write port among
//            NUM_REQ valid/ready requesters, honouring the FIFO full flag.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic                       fifo_full_i,
    output logic                       fifo_wr_en_o,
    output logic [DATA_W-1:0]          fifo_wr_data_o,
    output logic                       grant_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    localparam logic [ID_W-1:0]  c_last_id   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            state_q,    state_d;
    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic [DATA_W-1:0]    w_req_data [NUM_REQ];
    logic [2*NUM_REQ-1:0] w_valid_dbl;
    logic                 w_found;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W-1:0]      w_next_ptr;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_data[gi] = req_data_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Doubling the request vector turns the wrapped search into a plain
    // lowest-index search over positions at or above rr_ptr.
    assign w_valid_dbl = {req_valid_i, req_valid_i};

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
            if (w_valid_dbl[j] && (j >= int'(rr_ptr_q))) begin
                w_found  = 1'b1;
                w_winner = ID_W'((j >= NUM_REQ) ? (j - NUM_REQ) : j);
            end
        end
    end

    assign w_next_ptr = (grant_id_q == c_last_id) ? '0 : grant_id_q + 1'b1;

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        beat_cnt_d     = beat_cnt_q;
        req_ready_o    = '0;
        fifo_wr_en_o   = 1'b0;
        fifo_wr_data_o = '0;
        grant_valid_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_id_d = w_winner;
                    beat_cnt_d = '0;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                grant_valid_o           = 1'b1;
                req_ready_o[grant_id_q] = !fifo_full_i;
                fifo_wr_en_o            = req_valid_i[grant_id_q] & !fifo_full_i;
                fifo_wr_data_o          = w_req_data[grant_id_q];
                if (!req_valid_i[grant_id_q]) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = w_next_ptr;
                end else if (!fifo_full_i) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == c_last_beat) begin
                        state_d  = S_IDLE;
                        rr_ptr_d = w_next_ptr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign grant_id_o = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter (vectors, sequences,
//            randomized traffic against a rule-level model).
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                      wr_clk = 1'b0;
    logic                      wr_rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic                      fifo_full = 1'b0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_wr_data;
    logic                      grant_valid;
    logic [1:0]                grant_id;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wr_clk         (wr_clk),
        .wr_rst         (wr_rst),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .fifo_full_i    (fifo_full),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_wr_data_o (fifo_wr_data),
        .grant_valid_o  (grant_valid),
        .grant_id_o     (grant_id)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Per-requester stream position: requester r offers (r+1)*16 + seq[r].
    int seq [NUM_REQ];

    // Reference model: owner of the port (-1 when nobody), beats taken so far,
    // where the next search starts, and the last granted requester.
    int m_owner, m_beats, m_ptr, m_last;

    logic              o_gv, o_wen;
    logic [1:0]        o_gid;
    logic [3:0]        o_rdy;
    logic [7:0]        o_data;

    typedef struct {
        bit         rst_first;
        logic [3:0] v;
        logic       f;
        logic       gv;
        logic [1:0] gid;
        logic [3:0] rdy;
        logic       wen;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] word(input int r);
        return 8'((r + 1) * 16 + seq[r]);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_ptr   = 0;
        m_last  = 0;
    endtask

    task automatic model_release();
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
    endtask

    task automatic do_reset();
        wr_rst    = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        req_data  = '0;
        for (int r = 0; r < NUM_REQ; r++) seq[r] = 0;
        model_reset();
        #1;
        check("reset grant_valid", grant_valid, 0);
        check("reset grant_id", grant_id, 0);
        check("reset req_ready", req_ready, 0);
        check("reset wr_en", fifo_wr_en, 0);
        check("reset wr_data", fifo_wr_data, 0);
        repeat (2) @(posedge wr_clk);
        #1 wr_rst = 1'b1;
    endtask

    // One clock cycle: drive, compare against the model at negedge, advance model.
    task automatic step(input logic [3:0] v, input logic f);
        logic [3:0] e_rdy;
        logic       e_wen;
        logic [7:0] e_data;
        int         j;
        req_valid = v;
        fifo_full = f;
        for (int r = 0; r < NUM_REQ; r++) req_data[r*8 +: 8] = word(r);
        @(negedge wr_clk);
        o_gv = grant_valid; o_gid = grant_id; o_rdy = req_ready;
        o_wen = fifo_wr_en; o_data = fifo_wr_data;
        e_rdy = '0; e_wen = 1'b0; e_data = '0;
        if (wr_rst && m_owner >= 0) begin
            e_rdy  = f ? 4'b0000 : 4'(1 << m_owner);
            e_wen  = v[m_owner] & !f;
            e_data = word(m_owner);
        end
        check("model grant_valid", o_gv, (wr_rst && m_owner >= 0));
        check("model grant_id", o_gid, m_last);
        check("model req_ready", o_rdy, e_rdy);
        check("model wr_en", o_wen, e_wen);
        check("model wr_data", o_data, e_data);
        @(posedge wr_clk);
        if (!wr_rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j = (m_ptr + k) % NUM_REQ;
                if (m_owner < 0 && v[j]) begin
                    m_owner = j;
                    m_last  = j;
                    m_beats = 0;
                end
            end
        end else if (!v[m_owner]) begin
            model_release();
        end else if (!f) begin
            seq[m_owner]++;
            m_beats++;
            if (m_beats == MAX_BURST) model_release();
        end
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nw;
        bit   found;
        logic [3:0] rv;

        // Requester 0 streaming alone: 4 beats, 1 idle cycle, again.
        vecs.push_back('{1, 4'b0001, 0, 0, 0, 4'b0000, 0, 8'h00});
        for (int k = 0; k < 4; k++)
            vecs.push_back('{0, 4'b0001, 0, 1, 0, 4'b0001, 1, 8'(8'h10 + k)});
        vecs.push_back('{0, 4'b0001, 0, 0, 0, 4'b0000, 0, 8'h00});
        for (int k = 4; k < 8; k++)
            vecs.push_back('{0, 4'b0001, 0, 1, 0, 4'b0001, 1, 8'(8'h10 + k)});
        vecs.push_back('{0, 4'b0001, 0, 0, 0, 4'b0000, 0, 8'h00});
        // Requester 2 stalled by full after two beats for 5 cycles.
        vecs.push_back('{1, 4'b0100, 0, 0, 0, 4'b0000, 0, 8'h00});
        vecs.push_back('{0, 4'b0100, 0, 1, 2, 4'b0100, 1, 8'h30});
        vecs.push_back('{0, 4'b0100, 0, 1, 2, 4'b0100, 1, 8'h31});
        for (int k = 0; k < 5; k++)
            vecs.push_back('{0, 4'b0100, 1, 1, 2, 4'b0000, 0, 8'h32});
        vecs.push_back('{0, 4'b0100, 0, 1, 2, 4'b0100, 1, 8'h32});
        vecs.push_back('{0, 4'b0100, 0, 1, 2, 4'b0100, 1, 8'h33});
        vecs.push_back('{0, 4'b0100, 0, 0, 2, 4'b0000, 0, 8'h00});
        vecs.push_back('{0, 4'b0100, 0, 1, 2, 4'b0100, 1, 8'h34});
        // Requester 1 releases after two beats; requester 3 is next.
        vecs.push_back('{1, 4'b1010, 0, 0, 0, 4'b0000, 0, 8'h00});
        vecs.push_back('{0, 4'b1010, 0, 1, 1, 4'b0010, 1, 8'h20});
        vecs.push_back('{0, 4'b1010, 0, 1, 1, 4'b0010, 1, 8'h21});
        vecs.push_back('{0, 4'b1000, 0, 1, 1, 4'b0010, 0, 8'h22});
        vecs.push_back('{0, 4'b1000, 0, 0, 1, 4'b0000, 0, 8'h00});
        vecs.push_back('{0, 4'b1000, 0, 1, 3, 4'b1000, 1, 8'h40});

        #2;
        do_reset();

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            step(4'b0000, 1'b0);
            check($sformatf("idle%0d grant_valid", c), o_gv, 0);
            check($sformatf("idle%0d wr_en", c), o_wen, 0);
            check($sformatf("idle%0d req_ready", c), o_rdy, 0);
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            step(vecs[i].v, vecs[i].f);
            check($sformatf("vec%0d grant_valid", i), o_gv, vecs[i].gv);
            check($sformatf("vec%0d grant_id", i), o_gid, vecs[i].gid);
            check($sformatf("vec%0d req_ready", i), o_rdy, vecs[i].rdy);
            check($sformatf("vec%0d wr_en", i), o_wen, vecs[i].wen);
            check($sformatf("vec%0d wr_data", i), o_data, vecs[i].data);
        end

        // All four requesting: order 0,1,2,3, 16 writes in 20 cycles.
        do_reset();
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            step(4'b1111, 1'b0);
            if (o_wen) begin
                if (nw < 16)
                    check($sformatf("rr write%0d", nw), o_data, 8'((nw / 4 + 1) * 16 + nw % 4));
                nw++;
            end
        end
        check("rr write count", nw, 16);
        step(4'b1111, 1'b0);
        check("rr wrap idle", o_gv, 0);
        step(4'b1111, 1'b0);
        check("rr wrap grant_id", o_gid, 0);
        check("rr wrap wr_data", o_data, 8'h14);

        // Reset pulse in the middle of requester 2's burst.
        do_reset();
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        req_valid = 4'b0110;
        wr_rst    = 1'b0;
        #1;
        check("midrst grant_valid", grant_valid, 0);
        check("midrst wr_en", fifo_wr_en, 0);
        check("midrst req_ready", req_ready, 0);
        check("midrst wr_data", fifo_wr_data, 0);
        model_reset();
        step(4'b0110, 1'b0);
        step(4'b0110, 1'b0);
        wr_rst = 1'b1;
        step(4'b0110, 1'b0);
        check("midrst arb idle", o_gv, 0);
        step(4'b0110, 1'b0);
        check("midrst first grant", o_gid, 1);
        check("midrst first data", o_data, 8'h20);
        found = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(4'b0110, 1'b0);
            if (!found && o_wen && o_gid == 2) begin
                found = 1'b1;
                check("midrst resumed data", o_data, 8'h31);
            end
        end
        check("midrst req2 served", found, 1);

        // Randomized traffic with back-pressure.
        do_reset();
        rv = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NUM_REQ; r++)
                if ($urandom_range(0, 7) == 0) rv[r] = ~rv[r];
            step(rv, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
